// File: rtl/p_unprojection_if.sv
// Request/result bundle for the unprojection block: a screen pixel plus depth
// going in, the recovered view-space coordinates and status flags coming out.
interface p_unprojection_if;
  // Request side
  logic               in_valid;
  logic               in_ready;
  logic signed [9:0]  x_screen;
  logic signed [9:0]  y_screen;
  logic signed [31:0] z;

  // Result side
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] x_view;
  logic signed [31:0] y_view;
  logic               edge_flag;
  logic               zero_z;

  // The unprojection block itself
  modport slave (
    input  in_valid, x_screen, y_screen, z, out_ready,
    output in_ready, out_valid, x_view, y_view, edge_flag, zero_z
  );

  // Whoever issues requests and consumes results
  modport master (
    output in_valid, x_screen, y_screen, z, out_ready,
    input  in_ready, out_valid, x_view, y_view, edge_flag, zero_z
  );
endinterface

// File: rtl/p_unprojection.sv
// Screen-to-view unprojection:
//   x_view = floor((x_screen - CX) * z / 2^D_SHIFT)
//   y_view = floor((CY - y_screen) * z / 2^D_SHIFT)
// A shift-add multiplier walks the centred-coordinate magnitudes one bit per
// cycle (MAG_W cycles), then one finishing cycle applies sign, floor-shift and
// 32-bit saturation. One transaction in flight; fixed latency regardless of data.
module p_unprojection #(
  parameter int CX      = 160,
  parameter int CY      = 90,
  parameter int D_SHIFT = 6,
  parameter int CLAMP   = 256,
  parameter int MAG_W   = 10
) (
  input  logic            CLK,
  input  logic            RESET_N,
  p_unprojection_if.slave bus
);

  // Accumulator holds |d| * z with room for the sign bit.
  localparam int ACC_W = 32 + MAG_W + 1;
  localparam int CNT_W = $clog2(MAG_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_FIN,
    S_HOLD
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [MAG_W-1:0]          x_mag_q, x_mag_d;
  logic [MAG_W-1:0]          y_mag_q, y_mag_d;
  logic                      x_neg_q, x_neg_d;
  logic                      y_neg_q, y_neg_d;
  logic signed [ACC_W-1:0]   zsh_q, zsh_d;
  logic signed [ACC_W-1:0]   x_acc_q, x_acc_d;
  logic signed [ACC_W-1:0]   y_acc_q, y_acc_d;
  logic                      edge_pend_q, edge_pend_d;
  logic                      zero_pend_q, zero_pend_d;
  logic                      out_valid_q, out_valid_d;
  logic [31:0]               x_view_q, x_view_d;
  logic [31:0]               y_view_q, y_view_d;
  logic                      edge_q, edge_d;
  logic                      zero_q, zero_d;

  logic signed [10:0]        dx;
  logic signed [10:0]        dy;
  logic [MAG_W-1:0]          dx_mag;
  logic [MAG_W-1:0]          dy_mag;

  // Apply the coordinate sign, floor-divide by 2^D_SHIFT and clamp to int32.
  // The range check looks at the full-width value before it is truncated.
  function automatic logic [31:0] finish_acc(input logic signed [ACC_W-1:0] acc,
                                             input logic neg);
    logic signed [ACC_W-1:0] signed_prod;
    logic signed [ACC_W-1:0] shifted;
    signed_prod = neg ? -acc : acc;
    shifted     = signed_prod >>> D_SHIFT;
    if ((&shifted[ACC_W-1:31]) || (~|shifted[ACC_W-1:31])) begin
      return shifted[31:0];
    end else if (shifted[ACC_W-1]) begin
      return 32'h8000_0000;
    end else begin
      return 32'h7FFF_FFFF;
    end
  endfunction

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.x_view    = x_view_q;
  assign bus.y_view    = y_view_q;
  assign bus.edge_flag = edge_q;
  assign bus.zero_z    = zero_q;

  // Centre the incoming pixel and split it into sign and magnitude.
  always_comb begin
    dx     = {bus.x_screen[9], bus.x_screen} - 11'(CX);
    dy     = 11'(CY) - {bus.y_screen[9], bus.y_screen};
    dx_mag = dx[10] ? MAG_W'(-dx) : MAG_W'(dx);
    dy_mag = dy[10] ? MAG_W'(-dy) : MAG_W'(dy);
  end

  // Next-state and datapath: accept, shift-add, finish, hold for handoff.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_mag_d     = x_mag_q;
    y_mag_d     = y_mag_q;
    x_neg_d     = x_neg_q;
    y_neg_d     = y_neg_q;
    zsh_d       = zsh_q;
    x_acc_d     = x_acc_q;
    y_acc_d     = y_acc_q;
    edge_pend_d = edge_pend_q;
    zero_pend_d = zero_pend_q;
    out_valid_d = out_valid_q;
    x_view_d    = x_view_q;
    y_view_d    = y_view_q;
    edge_d      = edge_q;
    zero_d      = zero_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          x_mag_d     = dx_mag;
          y_mag_d     = dy_mag;
          x_neg_d     = dx[10];
          y_neg_d     = dy[10];
          zsh_d       = {{(ACC_W-32){bus.z[31]}}, bus.z};
          x_acc_d     = '0;
          y_acc_d     = '0;
          edge_pend_d = (dx_mag >= MAG_W'(CLAMP)) || (dy_mag >= MAG_W'(CLAMP));
          zero_pend_d = (bus.z == 32'sd0);
          cnt_d       = '0;
          state_d     = S_MUL;
        end
      end

      S_MUL: begin
        // Magnitudes shift right and the multiplicand shifts left, so bit 0
        // of each magnitude always gates z << cnt.
        if (x_mag_q[0]) x_acc_d = x_acc_q + zsh_q;
        if (y_mag_q[0]) y_acc_d = y_acc_q + zsh_q;
        x_mag_d = x_mag_q >> 1;
        y_mag_d = y_mag_q >> 1;
        zsh_d   = zsh_q <<< 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(MAG_W - 1)) begin
          state_d = S_FIN;
        end
      end

      S_FIN: begin
        x_view_d    = finish_acc(x_acc_q, x_neg_q);
        y_view_d    = finish_acc(y_acc_q, y_neg_q);
        edge_d      = edge_pend_q;
        zero_d      = zero_pend_q;
        out_valid_d = 1'b1;
        state_d     = S_HOLD;
      end

      S_HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      x_mag_q     <= '0;
      y_mag_q     <= '0;
      x_neg_q     <= 1'b0;
      y_neg_q     <= 1'b0;
      zsh_q       <= '0;
      x_acc_q     <= '0;
      y_acc_q     <= '0;
      edge_pend_q <= 1'b0;
      zero_pend_q <= 1'b0;
      out_valid_q <= 1'b0;
      x_view_q    <= '0;
      y_view_q    <= '0;
      edge_q      <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_mag_q     <= x_mag_d;
      y_mag_q     <= y_mag_d;
      x_neg_q     <= x_neg_d;
      y_neg_q     <= y_neg_d;
      zsh_q       <= zsh_d;
      x_acc_q     <= x_acc_d;
      y_acc_q     <= y_acc_d;
      edge_pend_q <= edge_pend_d;
      zero_pend_q <= zero_pend_d;
      out_valid_q <= out_valid_d;
      x_view_q    <= x_view_d;
      y_view_q    <= y_view_d;
      edge_q      <= edge_d;
      zero_q      <= zero_d;
    end
  end

endmodule

// File: tb/tb_p_unprojection.sv
// Directed plus randomized bench for p_unprojection. Expected values come from
// a plain-arithmetic model of the unprojection formula (64-bit product, floor
// division, int32 clamp).
module tb_p_unprojection;

  logic CLK;
  logic RESET_N;
  int   vectors;
  int   miscompares;

  p_unprojection_if bus();

  p_unprojection dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // One comparison point.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: floor(d * z / 64) clamped to the int32 range.
  function automatic longint model_axis(input longint d, input longint zz);
    longint p, q;
    p = d * zz;
    q = p / 64;
    if ((p % 64) != 0 && p < 0) q = q - 1;
    if (q > 64'sd2147483647) q = 64'sd2147483647;
    if (q < -64'sd2147483648) q = -64'sd2147483648;
    return q;
  endfunction

  function automatic longint iabs(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  // Full transaction: request, latency/in_ready check, result check,
  // optional backpressure, handoff.
  task automatic do_txn(input int xs, input int ys, input int zz, input int hold);
    longint dxm, dym, ex, ey;
    logic   ee, ez, ir_bad;
    int     cyc;
    dxm = longint'(xs) - 160;
    dym = 90 - longint'(ys);
    ex  = model_axis(dxm, longint'(zz));
    ey  = model_axis(dym, longint'(zz));
    ee  = (iabs(dxm) >= 256) || (iabs(dym) >= 256);
    ez  = (zz == 0);

    @(negedge CLK);
    chk("in_ready_before", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.x_screen = 10'(xs);
    bus.y_screen = 10'(ys);
    bus.z        = zz;
    bus.out_ready = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    bus.in_valid = 1'b0;
    bus.x_screen = 10'($urandom);
    bus.y_screen = 10'($urandom);
    bus.z        = $urandom;
    cyc    = 0;
    ir_bad = 1'b0;
    while (!bus.out_valid && cyc < 50) begin
      if (bus.in_ready !== 1'b0) ir_bad = 1'b1;
      @(negedge CLK);
      cyc++;
    end
    chk("latency", 32'(cyc), 32'd11);
    chk("in_ready_busy", 32'(ir_bad), 32'd0);
    chk("x_view", bus.x_view, 32'(ex));
    chk("y_view", bus.y_view, 32'(ey));
    chk("edge_flag", 32'(bus.edge_flag), 32'(ee));
    chk("zero_z", 32'(bus.zero_z), 32'(ez));
    $display("txn xs=%0d ys=%0d z=%0d -> x_view=%0d y_view=%0d edge=%0b zero=%0b lat=%0d",
             xs, ys, zz, bus.x_view, bus.y_view, bus.edge_flag, bus.zero_z, cyc);

    for (int h = 0; h < hold; h++) begin
      @(negedge CLK);
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      chk("hold_x_view", bus.x_view, 32'(ex));
      chk("hold_y_view", bus.y_view, 32'(ey));
    end

    bus.out_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    bus.out_ready = 1'b0;
    chk("handoff_valid", 32'(bus.out_valid), 32'd0);
    chk("handoff_in_ready", 32'(bus.in_ready), 32'd1);
    chk("after_x_view", bus.x_view, 32'(ex));
  endtask

  initial begin
    int seen_valid;
    vectors       = 0;
    miscompares   = 0;
    RESET_N       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.x_screen  = '0;
    bus.y_screen  = '0;
    bus.z         = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_x_view", bus.x_view, 32'd0);
    chk("rst_y_view", bus.y_view, 32'd0);
    chk("rst_edge", 32'(bus.edge_flag), 32'd0);
    chk("rst_zero", 32'(bus.zero_z), 32'd0);
    RESET_N = 1'b1;
    @(negedge CLK);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Directed cases, first one with 5 cycles of backpressure
    do_txn(224, 26, 100, 5);
    do_txn(96, 154, 100, 0);
    do_txn(161, 89, 1, 0);
    do_txn(159, 91, 1, 1);
    do_txn(511, -512, 32'h7FFF_FFFF, 0);
    do_txn(511, -512, 32'h8000_0000, 0);
    do_txn(300, 26, 0, 0);
    do_txn(-512, 511, -7, 2);

    // Randomized cases
    for (int i = 0; i < 24; i++) begin
      int xs, ys, zz;
      xs = int'($urandom_range(1023)) - 512;
      ys = int'($urandom_range(1023)) - 512;
      if (i % 2 == 0) zz = int'($urandom);
      else            zz = int'($urandom_range(4000)) - 2000;
      do_txn(xs, ys, zz, int'($urandom_range(3)));
    end

    // Reset during MUL cycle 4 aborts the transaction
    @(negedge CLK);
    bus.in_valid = 1'b1;
    bus.x_screen = 10'(224);
    bus.y_screen = 10'(26);
    bus.z        = 100;
    @(posedge CLK);
    @(negedge CLK);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge CLK);
    RESET_N = 1'b0;
    @(negedge CLK);
    chk("abort_x_view", bus.x_view, 32'd0);
    chk("abort_y_view", bus.y_view, 32'd0);
    RESET_N = 1'b1;
    @(negedge CLK);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    seen_valid = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge CLK);
      if (bus.out_valid !== 1'b0) seen_valid = 1;
    end
    chk("abort_no_valid", 32'(seen_valid), 32'd0);
    $display("txn reset-abort: out_valid never rose=%0d", seen_valid == 0);

    // Still functional after the abort
    do_txn(96, 154, 100, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
